hazard_stage: RTL and testbench

Parametrised buffered-handshake pipeline stage for the packet-filter CPU controller. It accepts instruction words under a valid/ready handshake and holds up to DEPTH of them in a circular queue. An external hazard `stall` blocks acceptance. A `flush` (branch mispredict) empties the stage. Each held word carries a saturating age counter of the cycles it has spent in the pipeline, and the block emits a one-cycle `accept` pulse that downstream decode logic uses to gate its "hot" enables.

---
 rtl/hazard_stage_pkg.sv | 21 ++
 rtl/hazard_stage_if.sv | 31 +++
 rtl/hazard_stage_sat_counter.sv | 21 ++
 rtl/hazard_stage.sv | 97 +++++++++
 tb/tb_hazard_stage.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_stage_pkg.sv
// Shared helpers for the hazard stage: constant log2 and the saturating increment
// used both when a word is accepted and when held entries age.
package hazard_stage_pkg;

   localparam int unsigned SAT_W = 32;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(n)) r = r + 1;
      return r;
   endfunction

   // Increment v, clamping at the all-ones value of a w-bit field
   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v, input int unsigned w);
      logic [SAT_W-1:0] max_v;
      max_v = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
      return (v >= max_v) ? max_v : v + SAT_W'(1);
   endfunction

endpackage

// File: rtl/hazard_stage_if.sv
// Handshake bundle between upstream, the hazard stage and downstream decode.
interface hazard_stage_if #(
   parameter int unsigned DATA_WIDTH  = 64,
   parameter int unsigned COUNT_WIDTH = 6,
   parameter int unsigned DEPTH       = 2
);
   localparam int unsigned LVL_W = hazard_stage_pkg::clog2(DEPTH + 1);

   logic                   flush;
   logic                   stall;
   logic [DATA_WIDTH-1:0]  idata;
   logic [COUNT_WIDTH-1:0] icount;
   logic                   idata_vld;
   logic                   idata_rdy;
   logic [DATA_WIDTH-1:0]  odata;
   logic [COUNT_WIDTH-1:0] ocount;
   logic                   odata_vld;
   logic                   odata_rdy;
   logic                   accept;
   logic [LVL_W-1:0]       level;

   modport master (
      output flush, stall, idata, icount, idata_vld, odata_rdy,
      input  idata_rdy, odata, ocount, odata_vld, accept, level
   );

   modport slave (
      input  flush, stall, idata, icount, idata_vld, odata_rdy,
      output idata_rdy, odata, ocount, odata_vld, accept, level
   );
endinterface

// File: rtl/hazard_stage_sat_counter.sv
// Per-entry age counter: loads a value on push, otherwise counts up and sticks at all-ones.
module sat_counter
   import hazard_stage_pkg::*;
#(
   parameter int unsigned WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             inc,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       count <= '0;
      else if (load) count <= load_val;
      else if (inc)  count <= WIDTH'(sat_inc(SAT_W'(count), WIDTH));
   end

endmodule

// File: rtl/hazard_stage.sv
// Buffered valid/ready pipeline stage with stall, flush and per-word saturating age.
module hazard_stage
   import hazard_stage_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 64,
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned COUNT_WIDTH  = 6,
   parameter int unsigned ENABLE_COUNT = 1
) (
   input  logic          clk,
   input  logic          rst,
   hazard_stage_if.slave bus
);

   localparam int unsigned PTR_W = clog2(DEPTH);
   localparam int unsigned LVL_W = clog2(DEPTH + 1);

   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [LVL_W-1:0]      level_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  push;
   logic                  pop;

   // Ready depends only on occupancy and the hazard inputs, never on odata_rdy
   assign bus.idata_rdy = !rst && (level_q != LVL_W'(DEPTH)) && !bus.stall && !bus.flush;
   assign push          = bus.idata_vld && bus.idata_rdy;
   assign bus.accept    = push;
   assign bus.odata_vld = (level_q != '0);
   assign pop           = bus.odata_vld && bus.odata_rdy;
   assign bus.odata     = mem[rd_ptr];
   assign bus.level     = level_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else if (bus.flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= bus.idata;
      end
   end

   if (ENABLE_COUNT != 0) begin : g_count
      logic [COUNT_WIDTH-1:0] cnt [DEPTH];
      logic [COUNT_WIDTH-1:0] load_val;

      assign load_val = COUNT_WIDTH'(sat_inc(SAT_W'(bus.icount), COUNT_WIDTH));

      for (genvar i = 0; i < int'(DEPTH); i++) begin : g_entry
         logic [PTR_W-1:0] offset;
         logic             held;
         logic             load;
         logic             inc;

         // Entry is occupied when its distance from the head is below the level
         assign offset = PTR_W'(i) - rd_ptr;
         assign held   = (LVL_W'(offset) < level_q);
         assign load   = push && (wr_ptr == PTR_W'(i));
         assign inc    = held && !(pop && (rd_ptr == PTR_W'(i)));

         sat_counter #(.WIDTH(COUNT_WIDTH)) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .load     (load),
            .inc      (inc),
            .load_val (load_val),
            .count    (cnt[i])
         );
      end

      assign bus.ocount = cnt[rd_ptr];
   end else begin : g_nocount
      logic unused_icount;
      assign unused_icount = ^bus.icount;
      assign bus.ocount    = '0;
   end

endmodule

// File: tb/tb_hazard_stage.sv
// Directed bench for hazard_stage: a DEPTH=2 / 6-bit-age instance and a DEPTH=4 / 3-bit-age instance.
module tb_hazard_stage;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   hazard_stage_if #(.DATA_WIDTH(64), .COUNT_WIDTH(6), .DEPTH(2)) ia ();
   hazard_stage_if #(.DATA_WIDTH(64), .COUNT_WIDTH(3), .DEPTH(4)) ib ();

   hazard_stage #(.DATA_WIDTH(64), .DEPTH(2), .COUNT_WIDTH(6), .ENABLE_COUNT(1)) u_d2 (
      .clk (clk),
      .rst (rst),
      .bus (ia)
   );

   hazard_stage #(.DATA_WIDTH(64), .DEPTH(4), .COUNT_WIDTH(3), .ENABLE_COUNT(1)) u_d4 (
      .clk (clk),
      .rst (rst),
      .bus (ib)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int unsigned age_exp [4];
      age_exp = '{6, 7, 7, 7};

      rst = 1'b1;
      ia.flush = 0; ia.stall = 0; ia.idata = '0; ia.icount = '0; ia.idata_vld = 1; ia.odata_rdy = 0;
      ib.flush = 0; ib.stall = 0; ib.idata = '0; ib.icount = '0; ib.idata_vld = 0; ib.odata_rdy = 0;

      // Reset state
      tick();
      check("rst_idata_rdy", 64'(ia.idata_rdy), 64'd0);
      check("rst_accept",    64'(ia.accept),    64'd0);
      check("rst_odata_vld", 64'(ia.odata_vld), 64'd0);
      check("rst_level",     64'(ia.level),     64'd0);
      check("rst_odata",     ia.odata,          64'd0);
      check("rst_ocount",    64'(ia.ocount),    64'd0);
      check("rst_b_level",   64'(ib.level),     64'd0);
      rst = 1'b0;

      // Fill, then asynchronous reset mid-cycle
      ia.idata = 64'h11; ia.icount = 0; ia.idata_vld = 1;
      #1;
      check("pre_accept", 64'(ia.accept), 64'd1);
      tick();
      ia.idata = 64'h22;
      tick();
      ia.idata_vld = 0;
      check("pre_full_level", 64'(ia.level), 64'd2);
      check("pre_full_ocount", 64'(ia.ocount), 64'd2);
      #3 rst = 1'b1;
      #1;
      check("async_odata_vld", 64'(ia.odata_vld), 64'd0);
      check("async_level",     64'(ia.level),     64'd0);
      check("async_ocount",    64'(ia.ocount),    64'd0);
      #1 rst = 1'b0;
      ia.idata = 64'hA5; ia.icount = 3; ia.idata_vld = 1;
      #1;
      check("a5_accept", 64'(ia.accept), 64'd1);
      tick();
      ia.idata_vld = 0;
      check("a5_odata_vld", 64'(ia.odata_vld), 64'd1);
      check("a5_odata",     ia.odata,          64'hA5);
      check("a5_ocount",    64'(ia.ocount),    64'd4);
      check("a5_level",     64'(ia.level),     64'd1);
      ia.odata_rdy = 1;
      tick();
      ia.odata_rdy = 0;
      check("a5_drained", 64'(ia.odata_vld), 64'd0);

      // Streaming 1..8 through DEPTH=2 with downstream always ready
      for (int i = 1; i <= 8; i++) begin
         ia.idata = 64'(i); ia.icount = 0; ia.idata_vld = 1; ia.odata_rdy = 1;
         #1;
         check("stream_accept", 64'(ia.accept), 64'd1);
         check("stream_level",  64'(ia.level),  (i == 1) ? 64'd0 : 64'd1);
         if (i > 1) check("stream_odata", ia.odata, 64'(i - 1));
         tick();
      end
      ia.idata_vld = 0;
      #1;
      check("stream_last_odata",  ia.odata,          64'd8);
      check("stream_last_ocount", 64'(ia.ocount),    64'd1);
      check("stream_last_level",  64'(ia.level),     64'd1);
      tick();
      ia.odata_rdy = 0;
      check("stream_empty", 64'(ia.level), 64'd0);

      // Flush against a concurrent push and pop
      ia.idata = 64'h41; ia.idata_vld = 1;
      tick();
      ia.idata = 64'h42; ia.odata_rdy = 1; ia.flush = 1;
      #1;
      check("flush_rdy",    64'(ia.idata_rdy), 64'd0);
      check("flush_accept", 64'(ia.accept),    64'd0);
      tick();
      ia.flush = 0; ia.idata_vld = 0; ia.odata_rdy = 0;
      #1;
      check("flush_level",     64'(ia.level),     64'd0);
      check("flush_odata_vld", 64'(ia.odata_vld), 64'd0);
      check("flush_rdy_after", 64'(ia.idata_rdy), 64'd1);

      // Backpressure into DEPTH=4
      ib.odata_rdy = 0; ib.icount = 0; ib.idata_vld = 1;
      for (int k = 0; k < 3; k++) begin
         ib.idata = 64'hB1 + 64'(k);
         tick();
      end
      check("bp_level3", 64'(ib.level),     64'd3);
      check("bp_rdy3",   64'(ib.idata_rdy), 64'd1);
      ib.idata = 64'hB4;
      tick();
      ib.idata = 64'hB5;
      check("bp_level4",  64'(ib.level),     64'd4);
      check("bp_rdy4",    64'(ib.idata_rdy), 64'd0);
      check("bp_accept4", 64'(ib.accept),    64'd0);

      // Stall at full with a pop in the same cycle
      ib.stall = 1; ib.odata_rdy = 1;
      #1;
      check("stallfull_accept", 64'(ib.accept), 64'd0);
      check("stallfull_odata",  ib.odata,       64'hB1);
      tick();
      check("stallfull_level",   64'(ib.level),  64'd3);
      check("stallfull_accept2", 64'(ib.accept), 64'd0);
      ib.stall = 0; ib.idata_vld = 0;
      for (int k = 1; k <= 3; k++) begin
         check("drain_odata", ib.odata,       64'hB1 + 64'(k));
         check("drain_level", 64'(ib.level),  64'(4 - k));
         tick();
      end
      ib.odata_rdy = 0;
      check("drain_empty", 64'(ib.level), 64'd0);

      // Age saturation with a 3-bit counter
      ib.idata = 64'hC1; ib.icount = 5; ib.idata_vld = 1;
      tick();
      ib.idata_vld = 0;
      for (int k = 0; k < 4; k++) begin
         check("age_ocount", 64'(ib.ocount), 64'(age_exp[k]));
         tick();
      end
      ib.odata_rdy = 1;
      tick();
      ib.odata_rdy = 0;
      ib.idata = 64'hE1; ib.icount = 7; ib.idata_vld = 1;
      tick();
      ib.idata_vld = 0;
      check("push_sat_odata",  ib.odata,       64'hE1);
      check("push_sat_ocount", 64'(ib.ocount), 64'd7);
      ib.odata_rdy = 1;
      tick();
      ib.odata_rdy = 0;

      // Stall with two held words: no acceptance, normal drain
      ib.icount = 0; ib.idata_vld = 1; ib.idata = 64'hD1;
      tick();
      ib.idata = 64'hD2;
      tick();
      ib.idata = 64'hD3; ib.stall = 1;
      #1;
      check("stall_rdy",    64'(ib.idata_rdy), 64'd0);
      check("stall_accept", 64'(ib.accept),    64'd0);
      check("stall_level",  64'(ib.level),     64'd2);
      ib.odata_rdy = 1;
      #1;
      check("stall_odata1", ib.odata, 64'hD1);
      tick();
      check("stall_odata2",  ib.odata,       64'hD2);
      check("stall_level1",  64'(ib.level),  64'd1);
      check("stall_accept2", 64'(ib.accept), 64'd0);
      tick();
      check("stall_level0",  64'(ib.level),     64'd0);
      check("stall_vld0",    64'(ib.odata_vld), 64'd0);
      ib.stall = 0; ib.idata_vld = 0; ib.odata_rdy = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
